// File: rtl/instr_fetch_unit.sv
// Program store and fetch sequencer feeding the ALU execute stage.
// Steps mem[0..] out as opcode/a/b over valid/ready until a halt word or the last address.
module instr_fetch_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [19:0]       prog_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2:0]        opcode,
    output logic [7:0]        a,
    output logic [7:0]        b,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t state_q, state_d;

    logic [19:0] mem [DEPTH];
    logic [19:0] word;
    logic        idle_or_halt;
    logic        last;
    logic        xfer;

    assign word         = mem[pc];
    assign idle_or_halt = (state_q == IDLE) || (state_q == HALT);
    assign last         = (pc == ADDR_W'(DEPTH - 1));
    assign xfer         = out_valid && out_ready;

    assign busy   = (state_q == FETCH) || (state_q == ISSUE);
    assign halted = (state_q == HALT);

    // Writes are locked out while running so a fetch never races a write.
    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halt)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = word[19] ? HALT : ISSUE;
            ISSUE: if (xfer) state_d = last ? HALT : FETCH;
            HALT:  if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= '0;
            out_valid <= 1'b0;
            opcode    <= '0;
            a         <= '0;
            b         <= '0;
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (start)
                        pc <= '0;
                end
                FETCH: begin
                    if (!word[19]) begin
                        opcode    <= word[18:16];
                        a         <= word[15:8];
                        b         <= word[7:0];
                        out_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (!last)
                            pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
